// File: rtl/wishbone_if.sv
// 8-bit pipelined Wishbone bus bundle; signal suffixes are from the master's point of view.
interface wishbone_if;
  logic       cyc_o;
  logic       stb_o;
  logic       we_o;
  logic [7:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;
  logic       stall_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, stall_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, stall_i
  );
endinterface

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone (pipelined) master turning local write/read strobes into bus cycles.
// Define WISHBONE_MASTER_TIMEOUT_EN to abort transfers that see no ack within TIMEOUT_CYCLES.
module wishbone_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       burst_active,
  input  logic [7:0] write_data,
  input  logic [7:0] write_addr,
  input  logic       write_en,
  output logic       write_ready,
  output logic [7:0] read_data,
  input  logic [7:0] read_addr,
  input  logic       read_en,
  output logic       read_ready,
  wishbone_if.master wb_master
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] BUS_WAIT = 1'b1;

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  logic [0:0] master_state;
  logic       stb_q;
  logic       we_q;
  logic [7:0] adr_q;
  logic [7:0] dat_q;
  logic [7:0] read_data_q;
  logic       write_ready_q;
  logic       read_ready_q;

`ifdef WISHBONE_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      master_state  <= IDLE;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= 8'h00;
      dat_q         <= 8'h00;
      read_data_q   <= 8'h00;
      write_ready_q <= 1'b0;
      read_ready_q  <= 1'b0;
`ifdef WISHBONE_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      write_ready_q <= 1'b0;
      read_ready_q  <= 1'b0;
      if (master_state == IDLE) begin
        // Write wins when both requests are present.
        if (write_en) begin
          adr_q        <= write_addr;
          dat_q        <= write_data;
          we_q         <= 1'b1;
          stb_q        <= 1'b1;
          master_state <= BUS_WAIT;
`ifdef WISHBONE_MASTER_TIMEOUT_EN
          cnt_q        <= '0;
`endif
        end else if (read_en) begin
          adr_q        <= read_addr;
          we_q         <= 1'b0;
          stb_q        <= 1'b1;
          master_state <= BUS_WAIT;
`ifdef WISHBONE_MASTER_TIMEOUT_EN
          cnt_q        <= '0;
`endif
        end
      end else begin
        if (!wb_master.stall_i) stb_q <= 1'b0;
        if (wb_master.ack_i) begin
          stb_q        <= 1'b0;
          master_state <= IDLE;
          if (we_q) begin
            write_ready_q <= 1'b1;
          end else begin
            read_ready_q <= 1'b1;
            read_data_q  <= wb_master.dat_i;
          end
        end
`ifdef WISHBONE_MASTER_TIMEOUT_EN
        else if (cnt_q == CntMax) begin
          stb_q        <= 1'b0;
          master_state <= IDLE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
`endif
      end
    end
  end

  // Between transfers the bus is held only while the local side declares a burst.
  assign wb_master.cyc_o = (master_state == BUS_WAIT) | burst_active;
  assign wb_master.stb_o = stb_q;
  assign wb_master.we_o  = we_q;
  assign wb_master.adr_o = adr_q;
  assign wb_master.dat_o = dat_q;
  assign write_ready     = write_ready_q;
  assign read_ready      = read_ready_q;
  assign read_data       = read_data_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master with a completion scoreboard.
module tb_wishbone_master;

  logic       clk;
  logic       rst;
  logic       burst_active;
  logic [7:0] write_data;
  logic [7:0] write_addr;
  logic       write_en;
  logic       write_ready;
  logic [7:0] read_data;
  logic [7:0] read_addr;
  logic       read_en;
  logic       read_ready;

  wishbone_if wb ();

  wishbone_master dut (
    .clk          (clk),
    .rst          (rst),
    .burst_active (burst_active),
    .write_data   (write_data),
    .write_addr   (write_addr),
    .write_en     (write_en),
    .write_ready  (write_ready),
    .read_data    (read_data),
    .read_addr    (read_addr),
    .read_en      (read_en),
    .read_ready   (read_ready),
    .wb_master    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_write;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard on any completion pulse and checks its type and data.
  task automatic check_completion(input string tag);
    exp_t e;
    if (write_ready || read_ready) begin
      n_pulses++;
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_pulse"}, {30'd0, write_ready, read_ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_kind"}, {30'd0, write_ready, read_ready}, {30'd0, e.is_write, ~e.is_write});
        if (!e.is_write) chk({tag, "_rdata"}, {24'd0, read_data}, {24'd0, e.data});
      end
    end
  endtask

  initial begin
    rst = 1'b1; burst_active = 1'b0;
    write_data = 8'h00; write_addr = 8'h00; write_en = 1'b0;
    read_addr = 8'h00; read_en = 1'b0;
    wb.dat_i = 8'h00; wb.ack_i = 1'b0; wb.stall_i = 1'b0;

    // Reset
    repeat (10) tick();
    chk("rst_state", {31'd0, dut.master_state}, 32'd0);
    chk("rst_bus", {29'd0, wb.cyc_o, wb.stb_o, wb.we_o}, 32'd0);
    chk("rst_adr_dat", {16'd0, wb.adr_o, wb.dat_o}, 32'd0);
    chk("rst_local", {22'd0, read_data, write_ready, read_ready}, 32'd0);
    rst = 1'b0;

    // Write with a long stall, then accept+ack together
    burst_active = 1'b1;
    tick();
    chk("idle_burst_cyc", {31'd0, wb.cyc_o}, 32'd1);
    chk("idle_stb", {31'd0, wb.stb_o}, 32'd0);
    write_addr = 8'h80; write_data = 8'hAA; write_en = 1'b1; wb.stall_i = 1'b1;
    sb.push_back('{is_write: 1'b1, data: 8'hAA});
    tick();
    write_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("wr_state", {31'd0, dut.master_state}, 32'd1);
      chk("wr_bus", {29'd0, wb.cyc_o, wb.stb_o, wb.we_o}, 32'd7);
      chk("wr_adr_dat", {16'd0, wb.adr_o, wb.dat_o}, 32'h80AA);
      chk("wr_no_pulse", {30'd0, write_ready, read_ready}, 32'd0);
      tick();
    end
    wb.stall_i = 1'b0; wb.ack_i = 1'b1;
    tick();
    wb.ack_i = 1'b0;
    chk("wr_done_state", {31'd0, dut.master_state}, 32'd0);
    chk("wr_ready", {31'd0, write_ready}, 32'd1);
    chk("wr_done_stb", {31'd0, wb.stb_o}, 32'd0);
    check_completion("wr");
    tick();
    chk("wr_ready_one_cycle", {31'd0, write_ready}, 32'd0);
    chk("wr_burst_cyc_held", {31'd0, wb.cyc_o}, 32'd1);
    burst_active = 1'b0;
    #1;
    chk("idle_cyc_dropped", {31'd0, wb.cyc_o}, 32'd0);

    // Read with read_en held across the whole transfer wait
    read_addr = 8'h10; read_en = 1'b1; wb.stall_i = 1'b1; wb.dat_i = 8'h00;
    sb.push_back('{is_write: 1'b0, data: 8'h55});
    tick();
    for (int i = 0; i < 14; i++) begin
      chk("rd_state", {31'd0, dut.master_state}, 32'd1);
      chk("rd_bus", {29'd0, wb.cyc_o, wb.stb_o, wb.we_o}, 32'd6);
      chk("rd_adr", {24'd0, wb.adr_o}, 32'h10);
      tick();
    end
    read_en = 1'b0; wb.stall_i = 1'b0; wb.ack_i = 1'b1; wb.dat_i = 8'h55;
    tick();
    wb.ack_i = 1'b0; wb.dat_i = 8'hFF;
    chk("rd_ready", {31'd0, read_ready}, 32'd1);
    chk("rd_data", {24'd0, read_data}, 32'h55);
    check_completion("rd");
    tick();
    chk("rd_ready_one_cycle", {31'd0, read_ready}, 32'd0);
    chk("rd_data_held", {24'd0, read_data}, 32'h55);
    chk("rd_no_restart", {31'd0, dut.master_state}, 32'd0);

    // Ack while idle is ignored
    wb.ack_i = 1'b1;
    tick();
    wb.ack_i = 1'b0;
    chk("idle_ack_ignored", {29'd0, write_ready, read_ready, dut.master_state}, 32'd0);

    // Simultaneous requests: write first, minimum latency
    write_addr = 8'h33; write_data = 8'h5A; read_addr = 8'h44;
    write_en = 1'b1; read_en = 1'b1;
    sb.push_back('{is_write: 1'b1, data: 8'h5A});
    tick();
    write_en = 1'b0; read_en = 1'b0;
    chk("both_we", {31'd0, wb.we_o}, 32'd1);
    chk("both_adr_dat", {16'd0, wb.adr_o, wb.dat_o}, 32'h335A);
    wb.ack_i = 1'b1;
    tick();
    wb.ack_i = 1'b0;
    chk("both_ready", {30'd0, write_ready, read_ready}, 32'd2);
    check_completion("both");

    // Stall released at cycle 3, ack at cycle 6
    n_pulses = 0;
    read_addr = 8'h20; read_en = 1'b1; wb.stall_i = 1'b1;
    sb.push_back('{is_write: 1'b0, data: 8'h99});
    tick();
    read_en = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      wb.stall_i = (c < 3);
      wb.ack_i   = (c == 6);
      wb.dat_i   = 8'h99;
      tick();
      chk("st_stb", {31'd0, wb.stb_o}, {31'd0, (c < 3)});
      chk("st_cyc", {31'd0, wb.cyc_o}, {31'd0, (c < 6)});
      chk("st_ready", {31'd0, read_ready}, {31'd0, (c == 6)});
      check_completion("st");
    end
    wb.ack_i = 1'b0; wb.stall_i = 1'b0;
    chk("st_single_pulse", n_pulses, 32'd1);

    // Reset mid-transfer aborts without a pulse
    write_addr = 8'h01; write_data = 8'h02; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    chk("abort_started", {31'd0, dut.master_state}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_async", {28'd0, dut.master_state, wb.cyc_o, wb.stb_o, wb.we_o}, 32'd0);
    tick();
    rst = 1'b0;
    wb.ack_i = 1'b1;
    tick();
    wb.ack_i = 1'b0;
    chk("abort_no_pulse", {30'd0, write_ready, read_ready}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
